// File: rtl/chip8_pkg.sv
// chip8_pkg
//   Shared constants for the CHIP-8 display and the state encoding of the
//   sprite-draw FSM. No ports; imported by the sprite engine and its mask helper.
package chip8_pkg;

  localparam int SCREEN_W     = 64;
  localparam int SCREEN_H     = 32;
  localparam int FB_BYTES     = 256;
  localparam int FB_ROW_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_SPR,
    ST_RD_L,
    ST_WR_L,
    ST_RD_R,
    ST_WR_R,
    ST_DONE
  } spr_state_t;

endpackage

// File: rtl/chip8_sprite_mask.sv
// chip8_sprite_mask
//   Splits one sprite byte across the two framebuffer bytes it can touch when
//   drawn at a horizontal pixel offset inside a byte.
//   Ports:
//     spr        in  8  sprite row byte, MSB = leftmost pixel
//     off        in  3  x mod 8
//     left_mask  out 8  spr >> off
//     right_mask out 8  (spr << (8-off)) & 8'hFF; zero when off == 0
module chip8_sprite_mask
  import chip8_pkg::*;
(
  input  logic [7:0] spr,
  input  logic [2:0] off,
  output logic [7:0] left_mask,
  output logic [7:0] right_mask
);

  // Shifting the byte inside a 16-bit window yields both halves at once:
  // the bits that fall off the right of the left byte land in the low byte.
  logic [15:0] shifted;

  assign shifted    = {spr, 8'h00} >> off;
  assign left_mask  = shifted[15:8];
  assign right_mask = shifted[7:0];

endmodule

// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine
//   Executes the CHIP-8 DXYN draw: reads N sprite bytes from program memory at
//   I, XORs them into a 64x32 1bpp framebuffer (8 bytes per row, MSB leftmost),
//   wrapping at the right and bottom edges, and reports collision with done.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     start                      one-cycle draw request, accepted only in IDLE
//     x_coord, y_coord           Vx, Vy (sampled on accepted start)
//     n_rows, i_addr             sprite height N and base address I
//     busy, done, collision      status; collision is valid with done
//     mem_read/_idx/_ack/_byte   program-memory read handshake
//     fb_read/_idx/_ack/_byte    framebuffer read handshake
//     fb_write/_idx/_byte        framebuffer single-cycle write
module chip8_sprite_engine
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int FB_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           x_coord,
  input  logic [7:0]           y_coord,
  input  logic [3:0]           n_rows,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 collision,
  output logic                 mem_read,
  output logic [ADDR_W-1:0]    mem_read_idx,
  input  logic                 mem_read_ack,
  input  logic [7:0]           mem_read_byte,
  output logic                 fb_read,
  output logic [FB_ADDR_W-1:0] fb_read_idx,
  input  logic                 fb_read_ack,
  input  logic [7:0]           fb_read_byte,
  output logic                 fb_write,
  output logic [FB_ADDR_W-1:0] fb_write_idx,
  output logic [7:0]           fb_write_byte
);

  spr_state_t state, state_next;

  logic [3:0]        row_cnt;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] base_addr;
  logic [4:0]        y_q;
  logic [2:0]        col_q;
  logic [2:0]        off_q;
  logic [7:0]        spr_q;
  logic [7:0]        old_q;

  logic [7:0]           left_mask, right_mask, cur_mask;
  logic [4:0]           row_cur;
  logic [FB_ADDR_W-1:0] left_idx, right_idx;
  logic                 last_row;
  logic                 accept;

  // Only the low 6 bits of x and 5 bits of y matter on a 64x32 screen.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x_coord[7:6], y_coord[7:5]};

  chip8_sprite_mask u_mask (
    .spr        (spr_q),
    .off        (off_q),
    .left_mask  (left_mask),
    .right_mask (right_mask)
  );

  assign accept       = (state == ST_IDLE) && start;
  assign row_cur      = y_q + {1'b0, row_cnt};
  assign left_idx     = FB_ADDR_W'({row_cur, col_q});
  assign right_idx    = FB_ADDR_W'({row_cur, 3'(col_q + 3'd1)});
  assign last_row     = (4'(row_cnt + 4'd1) == n_q);
  assign mem_read_idx = base_addr + ADDR_W'(row_cnt);
  assign fb_write_byte = old_q ^ cur_mask;

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      row_cnt   <= 4'd0;
      collision <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        row_cnt   <= 4'd0;
        collision <= 1'b0;
      end
      if (fb_write) begin
        collision <= collision | (|(old_q & cur_mask));
      end
      if ((state == ST_WR_L && off_q == 3'd0) || state == ST_WR_R) begin
        row_cnt <= row_cnt + 4'd1;
      end
    end
  end

  // Datapath captures
  always_ff @(posedge clk) begin
    if (accept) begin
      n_q       <= n_rows;
      base_addr <= i_addr;
      y_q       <= y_coord[4:0];
      col_q     <= x_coord[5:3];
      off_q     <= x_coord[2:0];
    end
    if (state == ST_LOAD_SPR && mem_read_ack) begin
      spr_q <= mem_read_byte;
    end
    if ((state == ST_RD_L || state == ST_RD_R) && fb_read_ack) begin
      old_q <= fb_read_byte;
    end
  end

  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_read     = 1'b0;
    fb_read      = 1'b0;
    fb_write     = 1'b0;
    fb_read_idx  = left_idx;
    fb_write_idx = left_idx;
    cur_mask     = left_mask;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (n_rows == 4'd0) ? ST_DONE : ST_LOAD_SPR;
        end
      end
      ST_LOAD_SPR: begin
        busy     = 1'b1;
        mem_read = !mem_read_ack;
        if (mem_read_ack) state_next = ST_RD_L;
      end
      ST_RD_L: begin
        busy    = 1'b1;
        fb_read = !fb_read_ack;
        if (fb_read_ack) state_next = ST_WR_L;
      end
      ST_WR_L: begin
        busy     = 1'b1;
        fb_write = 1'b1;
        // A byte-aligned sprite never spills into the neighbouring byte.
        if (off_q != 3'd0) state_next = ST_RD_R;
        else               state_next = last_row ? ST_DONE : ST_LOAD_SPR;
      end
      ST_RD_R: begin
        busy        = 1'b1;
        fb_read     = !fb_read_ack;
        fb_read_idx = right_idx;
        if (fb_read_ack) state_next = ST_WR_R;
      end
      ST_WR_R: begin
        busy         = 1'b1;
        fb_write     = 1'b1;
        fb_write_idx = right_idx;
        cur_mask     = right_mask;
        state_next   = last_row ? ST_DONE : ST_LOAD_SPR;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_sprite_engine.sv
module tb_chip8_sprite_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x_coord, y_coord;
  logic [3:0]  n_rows;
  logic [11:0] i_addr;
  logic        busy, done, collision;
  logic        mem_read;
  logic [11:0] mem_read_idx;
  logic        mem_read_ack;
  logic [7:0]  mem_read_byte;
  logic        fb_read;
  logic [7:0]  fb_read_idx;
  logic        fb_read_ack;
  logic [7:0]  fb_read_byte;
  logic        fb_write;
  logic [7:0]  fb_write_idx;
  logic [7:0]  fb_write_byte;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem    [4096];
  logic [7:0] fb     [256];
  logic [7:0] exp_fb [256];
  bit         exp_col;

  logic        ld_fb, ld_mem;
  logic [7:0]  ld_idx;
  logic [11:0] ld_addr;
  logic [7:0]  ld_val;

  always #5 clk = ~clk;

  chip8_sprite_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .x_coord       (x_coord),
    .y_coord       (y_coord),
    .n_rows        (n_rows),
    .i_addr        (i_addr),
    .busy          (busy),
    .done          (done),
    .collision     (collision),
    .mem_read      (mem_read),
    .mem_read_idx  (mem_read_idx),
    .mem_read_ack  (mem_read_ack),
    .mem_read_byte (mem_read_byte),
    .fb_read       (fb_read),
    .fb_read_idx   (fb_read_idx),
    .fb_read_ack   (fb_read_ack),
    .fb_read_byte  (fb_read_byte),
    .fb_write      (fb_write),
    .fb_write_idx  (fb_write_idx),
    .fb_write_byte (fb_write_byte)
  );

  // Program memory and framebuffer with one-cycle registered read acks.
  always @(posedge clk) begin
    mem_read_ack  <= mem_read;
    mem_read_byte <= mem[mem_read_idx];
    fb_read_ack   <= fb_read;
    fb_read_byte  <= fb[fb_read_idx];
    if (fb_write) fb[fb_write_idx] <= fb_write_byte;
    if (ld_fb)    fb[ld_idx]       <= ld_val;
    if (ld_mem)   mem[ld_addr]     <= ld_val;
  end

  task automatic wr_fb(input int idx, input logic [7:0] v);
    @(negedge clk);
    ld_fb  = 1'b1;
    ld_idx = idx[7:0];
    ld_val = v;
    @(negedge clk);
    ld_fb = 1'b0;
    exp_fb[idx] = v;
  endtask

  task automatic wr_mem(input int addr, input logic [7:0] v);
    @(negedge clk);
    ld_mem  = 1'b1;
    ld_addr = addr[11:0];
    ld_val  = v;
    @(negedge clk);
    ld_mem = 1'b0;
  endtask

  task automatic clear_fb();
    for (int k = 0; k < 256; k++) wr_fb(k, 8'h00);
  endtask

  // Pixel-level reference: toggle each lit sprite pixel on a wrapping 64x32 screen.
  task automatic model_draw(input int x, input int y, input int n, input int i);
    logic [7:0] s;
    exp_col = 1'b0;
    for (int r = 0; r < n; r++) begin
      s = mem[(i + r) % 4096];
      for (int b = 0; b < 8; b++) begin
        if (s[7-b]) begin
          int px, py, idx, bt;
          px  = ((x % 64) + b) % 64;
          py  = ((y % 32) + r) % 32;
          idx = py * 8 + px / 8;
          bt  = 7 - (px % 8);
          if (exp_fb[idx][bt]) exp_col = 1'b1;
          exp_fb[idx][bt] = ~exp_fb[idx][bt];
        end
      end
    end
  endtask

  // Starts a draw and counts edges from the start-sampling edge to done.
  task automatic do_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                         input logic [11:0] i, input int restart_at,
                         output int cyc, output bit overlap, output bit traffic);
    overlap = 1'b0;
    traffic = 1'b0;
    @(negedge clk);
    x_coord = x; y_coord = y; n_rows = n; i_addr = i;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1;
        x_coord = 8'hAA; y_coord = 8'h55; n_rows = 4'hF; i_addr = 12'h777;
      end
      if (fb_read && fb_write) overlap = 1'b1;
      if (mem_read || fb_read || fb_write) traffic = 1'b1;
    end while (!done && cyc < 2000);
    start = 1'b0;
  endtask

  task automatic load_font();
    logic [7:0] f [5];
    f = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    for (int k = 0; k < 5; k++) wr_mem(12'h050 + k, f[k]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL reset_collision got=%b want=0", collision); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
    checks++; if (fb_read !== 1'b0) begin failures++; $display("FAIL reset_fb_read got=%b want=0", fb_read); end
    checks++; if (fb_write !== 1'b0) begin failures++; $display("FAIL reset_fb_write got=%b want=0", fb_write); end
    reset = 1'b0;
  endtask

  task automatic test_font(input bit redraw, input int restart_at, input string tag);
    int cyc; bit ov, tr;
    logic [7:0] f [5];
    f = redraw ? '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00} : '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    if (!redraw) clear_fb();
    model_draw(0, 0, 5, 12'h050);
    do_draw(8'd0, 8'd0, 4'd5, 12'h050, restart_at, cyc, ov, tr);
    checks++; if (cyc !== 26) begin failures++; $display("FAIL %s_latency got=%0d want=26", tag, cyc); end
    checks++; if (collision !== redraw) begin failures++; $display("FAIL %s_collision got=%b want=%b", tag, collision, redraw); end
    checks++; if (ov) begin failures++; $display("FAIL %s_rw_overlap got=1 want=0", tag); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (fb[k*8] !== f[k]) begin failures++; $display("FAIL %s_fb[%0d] got=%h want=%h", tag, k*8, fb[k*8], f[k]); end
    end
    if (restart_at > 0) begin
      // A start pulse in the DONE cycle must be ignored.
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL %s_done_start busy=%b done=%b want 0 0", tag, busy, done); end
    end
  endtask

  task automatic test_zero();
    int cyc; bit ov, tr;
    do_draw(8'd7, 8'd7, 4'd0, 12'h123, 0, cyc, ov, tr);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL zero_latency got=%0d want=1", cyc); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL zero_collision got=%b want=0", collision); end
    checks++; if (tr) begin failures++; $display("FAIL zero_traffic got=1 want=0"); end
  endtask

  task automatic test_split();
    int cyc; bit ov, tr;
    clear_fb();
    wr_mem(12'h200, 8'hFF);
    do_draw(8'd3, 8'd2, 4'd1, 12'h200, 0, cyc, ov, tr);
    checks++; if (cyc !== 9) begin failures++; $display("FAIL split_latency got=%0d want=9", cyc); end
    checks++; if (fb[16] !== 8'h1F) begin failures++; $display("FAIL split_fb16 got=%h want=1f", fb[16]); end
    checks++; if (fb[17] !== 8'hE0) begin failures++; $display("FAIL split_fb17 got=%h want=e0", fb[17]); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL split_collision got=%b want=0", collision); end
  endtask

  task automatic test_wrap();
    int cyc; bit ov, tr;
    clear_fb();
    wr_mem(12'hFFF, 8'hC3);
    wr_mem(12'h000, 8'hFF);
    do_draw(8'd62, 8'd31, 4'd2, 12'hFFF, 0, cyc, ov, tr);
    checks++; if (cyc !== 17) begin failures++; $display("FAIL wrap_latency got=%0d want=17", cyc); end
    checks++; if (fb[255] !== 8'h03) begin failures++; $display("FAIL wrap_fb255 got=%h want=03", fb[255]); end
    checks++; if (fb[248] !== 8'h0C) begin failures++; $display("FAIL wrap_fb248 got=%h want=0c", fb[248]); end
    checks++; if (fb[7] !== 8'h03) begin failures++; $display("FAIL wrap_fb7 got=%h want=03", fb[7]); end
    checks++; if (fb[0] !== 8'hFC) begin failures++; $display("FAIL wrap_fb0 got=%h want=fc", fb[0]); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL wrap_collision got=%b want=0", collision); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_fb();
    @(negedge clk);
    x_coord = 8'd0; y_coord = 8'd0; n_rows = 4'd5; i_addr = 12'h050;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end while (cyc < 12);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
    checks++; if ({mem_read, fb_read, fb_write, done} !== 4'b0000)
      begin failures++; $display("FAIL midreset_strobes got=%b want=0000", {mem_read, fb_read, fb_write, done}); end
    test_font(1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    int cyc, bad, first; bit ov, tr;
    logic [7:0] x, y; logic [3:0] n; logic [11:0] ia;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 256; k++)
        wr_fb(k, (it % 2 == 0) ? 8'($urandom & $urandom & $urandom) : 8'($urandom));
      x  = 8'($urandom);
      y  = 8'($urandom);
      n  = 4'($urandom_range(1, 15));
      ia = 12'($urandom);
      if (it == 0) x[2:0] = 3'd0;
      for (int r = 0; r < int'(n); r++) wr_mem((int'(ia) + r) % 4096, 8'($urandom));
      model_draw(int'(x), int'(y), int'(n), int'(ia));
      do_draw(x, y, n, ia, 0, cyc, ov, tr);
      checks++;
      if (cyc !== ((x[2:0] == 3'd0) ? 5 * int'(n) + 1 : 8 * int'(n) + 1))
        begin failures++; $display("FAIL rand%0d_latency got=%0d x=%0d n=%0d", it, cyc, x, n); end
      checks++;
      if (collision !== exp_col) begin failures++; $display("FAIL rand%0d_collision got=%b want=%b", it, collision, exp_col); end
      checks++;
      if (ov) begin failures++; $display("FAIL rand%0d_rw_overlap got=1 want=0", it); end
      bad = 0; first = -1;
      for (int k = 0; k < 256; k++) if (fb[k] !== exp_fb[k]) begin bad++; if (first < 0) first = k; end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand%0d_fb bytes_wrong=%0d first=%0d got=%h want=%h", it, bad, first, fb[first], exp_fb[first]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_fb = 1'b0; ld_mem = 1'b0;
    ld_idx = '0; ld_addr = '0; ld_val = '0;
    x_coord = '0; y_coord = '0; n_rows = '0; i_addr = '0;
    test_reset();
    load_font();
    test_font(1'b0, 0, "font");
    test_font(1'b1, 0, "redraw");
    test_zero();
    test_split();
    test_wrap();
    load_font();
    test_font(1'b0, 5, "restart");
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
